// File: rtl/data_mem_responder_pkg.sv
// Shared data-memory types: access widths, responder FSM states and lane geometry.
// The core's memory stage imports mem_width_t from here so both sides agree on the encoding.
package mem_types;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_width_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_t;

  localparam int LANE_BITS = 8;
  localparam int NUM_LANES = 4;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering for both directions of a 32-bit data access,
// plus detection of misaligned or invalid-width requests.
module mem_lane_align
  import mem_types::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]           i_addr_lo,
  input  logic [1:0]           i_width,
  input  logic                 i_sign_extend,
  input  logic [XLEN-1:0]      i_wdata,
  input  logic [XLEN-1:0]      i_rword,
  output logic [NUM_LANES-1:0] o_wstrb,
  output logic [XLEN-1:0]      o_wword,
  output logic [XLEN-1:0]      o_rdata,
  output logic                 o_misalign
);

  logic [4:0]      w_shamt;
  logic [XLEN-1:0] w_rshift;

  assign w_shamt  = {i_addr_lo, 3'b000};
  assign w_rshift = i_rword >> w_shamt;

  always_comb begin
    o_wstrb    = '0;
    o_wword    = i_wdata << w_shamt;
    o_rdata    = '0;
    o_misalign = 1'b0;
    case (i_width)
      BYTE: begin
        o_wstrb = 4'b0001 << i_addr_lo;
        o_rdata = {{(XLEN-8){i_sign_extend & w_rshift[7]}}, w_rshift[7:0]};
      end
      HALF: begin
        o_misalign = i_addr_lo[0];
        o_wstrb    = 4'b0011 << i_addr_lo;
        o_rdata    = {{(XLEN-16){i_sign_extend & w_rshift[15]}}, w_rshift[15:0]};
      end
      WORD: begin
        o_misalign = |i_addr_lo;
        o_wstrb    = '1;
        o_rdata    = w_rshift;
      end
      default: o_misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory target: valid/ready request in, fixed-latency response out, backed by an
// on-chip word RAM with byte-lane writes and extended sub-word reads.
module data_mem_responder
  import mem_types::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic            req_write,
  input  logic [1:0]      req_width,
  input  logic            req_sign_extend,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_fault
);

  localparam int              IDX_W   = $clog2(DEPTH_WORDS);
  localparam int              CNT_W   = $clog2(WAIT_CYCLES + 2);
  localparam logic [XLEN-3:0] C_DEPTH = (XLEN-2)'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] C_WAIT = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  resp_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_addr;
  logic [XLEN-1:0]  r_wdata;
  logic             r_write;
  logic             r_sext;
  logic [1:0]       r_width;
  logic             r_rsp_valid;
  logic [XLEN-1:0]  r_rsp_rdata;
  logic             r_rsp_fault;
  logic [XLEN-1:0]  r_mem [DEPTH_WORDS];

  logic                 w_in_idle;
  logic                 w_accept;
  logic                 w_do_access;
  logic [XLEN-1:0]      w_addr;
  logic [XLEN-1:0]      w_wdata;
  logic                 w_write;
  logic                 w_sext;
  logic [1:0]           w_width;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_oob;
  logic                 w_misalign;
  logic                 w_fault;
  logic                 w_we;
  logic [NUM_LANES-1:0] w_wstrb;
  logic [XLEN-1:0]      w_wword;
  logic [XLEN-1:0]      w_rdata;

  assign w_in_idle = (r_state == IDLE);
  assign w_accept  = w_in_idle & req_valid;

  // With zero wait the access lands on the accept edge, before the latch holds the request.
  assign w_addr  = w_in_idle ? req_addr        : r_addr;
  assign w_wdata = w_in_idle ? req_wdata       : r_wdata;
  assign w_write = w_in_idle ? req_write       : r_write;
  assign w_sext  = w_in_idle ? req_sign_extend : r_sext;
  assign w_width = w_in_idle ? req_width       : r_width;

  assign w_do_access = (WAIT_CYCLES == 0) ? w_accept
                                          : ((r_state == WAIT) && (r_cnt == C_ONE));

  assign w_idx   = w_addr[IDX_W+1:2];
  assign w_oob   = (w_addr[XLEN-1:2] >= C_DEPTH);
  assign w_fault = w_misalign | w_oob;
  assign w_we    = w_do_access & w_write & ~w_fault & reset_n;

  mem_lane_align #(
    .XLEN (XLEN)
  ) u_align (
    .i_addr_lo     (w_addr[1:0]),
    .i_width       (w_width),
    .i_sign_extend (w_sext),
    .i_wdata       (w_wdata),
    .i_rword       (r_mem[w_idx]),
    .o_wstrb       (w_wstrb),
    .o_wword       (w_wword),
    .o_rdata       (w_rdata),
    .o_misalign    (w_misalign)
  );

  // RAM contents survive reset; only the addressed lanes of a clean store are written.
  always_ff @(posedge clock) begin
    if (w_we) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (w_wstrb[i]) begin
          r_mem[w_idx][i*LANE_BITS +: LANE_BITS] <= w_wword[i*LANE_BITS +: LANE_BITS];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_write     <= 1'b0;
      r_sext      <= 1'b0;
      r_width     <= 2'b00;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_fault <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_write <= req_write;
            r_sext  <= req_sign_extend;
            r_width <= req_width;
            r_cnt   <= C_WAIT;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - C_ONE;
        end
        RESP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_do_access) begin
        r_state     <= RESP;
        r_rsp_valid <= 1'b1;
        r_rsp_fault <= w_fault;
        r_rsp_rdata <= (w_write | w_fault) ? '0 : w_rdata;
      end
    end
  end

  assign req_ready = w_in_idle;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_fault = r_rsp_fault;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a WAIT_CYCLES=2 instance for the main scenarios
// and a WAIT_CYCLES=0 instance for single-cycle latency.
module tb_data_mem_responder;
  import mem_types::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        req_valid, req_ready, req_write, req_sign_extend;
  logic [1:0]  req_width;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_fault;
  logic [31:0] rsp_rdata;

  logic        z_req_valid, z_req_ready, z_req_write, z_req_sign_extend;
  logic [1:0]  z_req_width;
  logic [31:0] z_req_addr, z_req_wdata;
  logic        z_rsp_valid, z_rsp_ready, z_rsp_fault;
  logic [31:0] z_rsp_rdata;

  int total = 0;
  int bad   = 0;

  data_mem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_width(req_width), .req_sign_extend(req_sign_extend),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault)
  );

  data_mem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_addr(z_req_addr),
    .req_write(z_req_write), .req_width(z_req_width), .req_sign_extend(z_req_sign_extend),
    .req_wdata(z_req_wdata), .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_fault(z_rsp_fault)
  );

  // Drives one request on the main instance and collects the response with rsp_ready high.
  // lat counts clock edges from the accept edge (counted as 1) to the edge raising rsp_valid.
  task automatic do_req(input logic [31:0] addr, input logic wr, input logic [1:0] wd,
                        input logic sx, input logic [31:0] wdat,
                        output logic [31:0] rd, output logic flt, output int lat);
    int n;
    @(negedge clock);
    req_valid = 1'b1; req_addr = addr; req_write = wr;
    req_width = wd; req_sign_extend = sx; req_wdata = wdat;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 50) begin
      @(posedge clock); #1;
      lat++;
    end
    rd  = rsp_rdata;
    flt = rsp_fault;
    if (rsp_valid === 1'b1) begin
      @(posedge clock); #1;
    end
    $display("txn addr=%h we=%0d width=%0d sx=%0d wdata=%h -> rdata=%h fault=%0d lat=%0d",
             addr, wr, wd, sx, wdat, rd, flt, lat);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata: got %h expected 00000000", rsp_rdata); end
    total++; if (rsp_fault !== 1'b0) begin bad++; $display("FAIL reset_rsp_fault: got %b expected 0", rsp_fault); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_word_rw();
    logic [31:0] rd; logic flt; int lat;
    do_req(32'h10, 1'b1, WORD, 1'b0, 32'hDEADBEEF, rd, flt, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL store_latency: got %0d expected 3", lat); end
    total++; if ({flt, rd} !== {1'b0, 32'h0}) begin bad++; $display("FAIL store_rsp: got fault=%b rdata=%h expected fault=0 rdata=00000000", flt, rd); end
    do_req(32'h10, 1'b0, WORD, 1'b0, 32'h0, rd, flt, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL load_latency: got %0d expected 3", lat); end
    total++; if ({flt, rd} !== {1'b0, 32'hDEADBEEF}) begin bad++; $display("FAIL load_word: got fault=%b rdata=%h expected fault=0 rdata=deadbeef", flt, rd); end
  endtask

  task automatic test_subword();
    logic [31:0] rd; logic flt; int lat;
    do_req(32'h13, 1'b1, BYTE, 1'b0, 32'h55555580, rd, flt, lat);
    total++; if (flt !== 1'b0) begin bad++; $display("FAIL byte_store_fault: got %b expected 0", flt); end
    do_req(32'h10, 1'b0, WORD, 1'b0, 32'h0, rd, flt, lat);
    total++; if (rd !== 32'h80ADBEEF) begin bad++; $display("FAIL byte_merge: got %h expected 80adbeef", rd); end
    do_req(32'h13, 1'b0, BYTE, 1'b1, 32'h0, rd, flt, lat);
    total++; if (rd !== 32'hFFFFFF80) begin bad++; $display("FAIL byte_sext: got %h expected ffffff80", rd); end
    do_req(32'h13, 1'b0, BYTE, 1'b0, 32'h0, rd, flt, lat);
    total++; if (rd !== 32'h00000080) begin bad++; $display("FAIL byte_zext: got %h expected 00000080", rd); end
    do_req(32'h12, 1'b0, HALF, 1'b1, 32'h0, rd, flt, lat);
    total++; if ({flt, rd} !== {1'b0, 32'hFFFF80AD}) begin bad++; $display("FAIL half_sext: got fault=%b rdata=%h expected fault=0 rdata=ffff80ad", flt, rd); end
    do_req(32'h11, 1'b0, BYTE, 1'b0, 32'h0, rd, flt, lat);
    total++; if (rd !== 32'h000000BE) begin bad++; $display("FAIL byte1_zext: got %h expected 000000be", rd); end
    do_req(32'h10, 1'b0, HALF, 1'b0, 32'h0, rd, flt, lat);
    total++; if (rd !== 32'h0000BEEF) begin bad++; $display("FAIL half0_zext: got %h expected 0000beef", rd); end
    do_req(32'h14, 1'b1, WORD, 1'b0, 32'h0, rd, flt, lat);
    do_req(32'h16, 1'b1, HALF, 1'b0, 32'h1234A5C3, rd, flt, lat);
    total++; if (flt !== 1'b0) begin bad++; $display("FAIL half_store_fault: got %b expected 0", flt); end
    do_req(32'h14, 1'b0, WORD, 1'b0, 32'h0, rd, flt, lat);
    total++; if (rd !== 32'hA5C30000) begin bad++; $display("FAIL half_merge: got %h expected a5c30000", rd); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic flt; int lat;
    do_req(32'h20, 1'b1, WORD, 1'b0, 32'h01020304, rd, flt, lat);
    do_req(32'h22, 1'b1, WORD, 1'b0, 32'h12345678, rd, flt, lat);
    total++; if ({flt, rd} !== {1'b1, 32'h0}) begin bad++; $display("FAIL misaligned_word_store: got fault=%b rdata=%h expected fault=1 rdata=00000000", flt, rd); end
    total++; if (lat !== 3) begin bad++; $display("FAIL fault_latency: got %0d expected 3", lat); end
    do_req(32'h23, 1'b1, HALF, 1'b0, 32'h0000FFFF, rd, flt, lat);
    total++; if (flt !== 1'b1) begin bad++; $display("FAIL misaligned_half_store: got fault=%b expected 1", flt); end
    do_req(32'h20, 1'b1, 2'b11, 1'b0, 32'hFFFFFFFF, rd, flt, lat);
    total++; if (flt !== 1'b1) begin bad++; $display("FAIL width11_store: got fault=%b expected 1", flt); end
    do_req(32'h20, 1'b0, WORD, 1'b0, 32'h0, rd, flt, lat);
    total++; if ({flt, rd} !== {1'b0, 32'h01020304}) begin bad++; $display("FAIL faulted_store_suppressed: got fault=%b rdata=%h expected fault=0 rdata=01020304", flt, rd); end
    do_req(32'h21, 1'b0, HALF, 1'b1, 32'h0, rd, flt, lat);
    total++; if ({flt, rd} !== {1'b1, 32'h0}) begin bad++; $display("FAIL misaligned_half_load: got fault=%b rdata=%h expected fault=1 rdata=00000000", flt, rd); end
    do_req(32'h20, 1'b0, 2'b11, 1'b0, 32'h0, rd, flt, lat);
    total++; if ({flt, rd} !== {1'b1, 32'h0}) begin bad++; $display("FAIL width11_load: got fault=%b rdata=%h expected fault=1 rdata=00000000", flt, rd); end
  endtask

  task automatic test_range();
    logic [31:0] rd; logic flt; int lat;
    do_req(32'h0, 1'b1, WORD, 1'b0, 32'h77777777, rd, flt, lat);
    do_req(32'h1000, 1'b0, WORD, 1'b0, 32'h0, rd, flt, lat);
    total++; if ({flt, rd} !== {1'b1, 32'h0}) begin bad++; $display("FAIL oob_load: got fault=%b rdata=%h expected fault=1 rdata=00000000", flt, rd); end
    do_req(32'h1000, 1'b1, WORD, 1'b0, 32'h99999999, rd, flt, lat);
    total++; if (flt !== 1'b1) begin bad++; $display("FAIL oob_store: got fault=%b expected 1", flt); end
    do_req(32'h0, 1'b0, WORD, 1'b0, 32'h0, rd, flt, lat);
    total++; if (rd !== 32'h77777777) begin bad++; $display("FAIL oob_store_suppressed: got %h expected 77777777", rd); end
    do_req(32'hFFC, 1'b1, WORD, 1'b0, 32'h55AA33CC, rd, flt, lat);
    total++; if (flt !== 1'b0) begin bad++; $display("FAIL last_word_store: got fault=%b expected 0", flt); end
    do_req(32'hFFC, 1'b0, WORD, 1'b0, 32'h0, rd, flt, lat);
    total++; if ({flt, rd} !== {1'b0, 32'h55AA33CC}) begin bad++; $display("FAIL last_word_load: got fault=%b rdata=%h expected fault=0 rdata=55aa33cc", flt, rd); end
  endtask

  task automatic test_backpressure();
    int n;
    rsp_ready = 1'b0;
    @(negedge clock);
    req_valid = 1'b1; req_addr = 32'h10; req_write = 1'b0;
    req_width = WORD; req_sign_extend = 1'b0; req_wdata = 32'h0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    n = 1;
    while (rsp_valid !== 1'b1 && n < 50) begin @(posedge clock); #1; n++; end
    total++; if (n !== 3) begin bad++; $display("FAIL bp_latency: got %0d expected 3", n); end
    @(negedge clock);
    req_valid = 1'b1; req_addr = 32'h14; req_write = 1'b0; req_width = WORD;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      total++;
      if ({rsp_valid, rsp_fault, req_ready, rsp_rdata} !== {3'b100, 32'h80ADBEEF}) begin
        bad++;
        $display("FAIL bp_hold_%0d: got valid=%b fault=%b req_ready=%b rdata=%h expected valid=1 fault=0 req_ready=0 rdata=80adbeef",
                 i, rsp_valid, rsp_fault, req_ready, rsp_rdata);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    total++; if ({rsp_valid, req_ready} !== 2'b01) begin bad++; $display("FAIL bp_release: got valid=%b req_ready=%b expected valid=0 req_ready=1", rsp_valid, req_ready); end
    @(posedge clock); #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_next_accept: got req_ready=%b expected 0", req_ready); end
    req_valid = 1'b0;
    n = 1;
    while (rsp_valid !== 1'b1 && n < 50) begin @(posedge clock); #1; n++; end
    total++; if ({n, rsp_rdata} !== {32'd3, 32'hA5C30000}) begin bad++; $display("FAIL bp_next_rsp: got lat=%0d rdata=%h expected lat=3 rdata=a5c30000", n, rsp_rdata); end
    @(posedge clock); #1;
    $display("txn backpressure pair done");
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic flt; int lat; int n;
    do_req(32'h40, 1'b1, WORD, 1'b0, 32'h11112222, rd, flt, lat);
    @(negedge clock);
    req_valid = 1'b1; req_addr = 32'h40; req_write = 1'b1;
    req_width = WORD; req_sign_extend = 1'b0; req_wdata = 32'hCAFEF00D;
    @(posedge clock); #1;
    req_valid = 1'b0;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL mid_in_wait: got req_ready=%b expected 0", req_ready); end
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    total++; if ({rsp_valid, req_ready} !== 2'b01) begin bad++; $display("FAIL mid_reset_state: got valid=%b req_ready=%b expected valid=0 req_ready=1", rsp_valid, req_ready); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    do_req(32'h40, 1'b0, WORD, 1'b0, 32'h0, rd, flt, lat);
    total++; if (rd !== 32'h11112222) begin bad++; $display("FAIL mid_store_discarded: got %h expected 11112222", rd); end
    // Reset while a load response is being held must clear it before any clock edge.
    rsp_ready = 1'b0;
    @(negedge clock);
    req_valid = 1'b1; req_addr = 32'h10; req_write = 1'b0; req_width = WORD;
    @(posedge clock); #1;
    req_valid = 1'b0;
    n = 1;
    while (rsp_valid !== 1'b1 && n < 50) begin @(posedge clock); #1; n++; end
    total++; if (rsp_rdata !== 32'h80ADBEEF) begin bad++; $display("FAIL held_rsp_data: got %h expected 80adbeef", rsp_rdata); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if ({rsp_valid, rsp_fault, rsp_rdata} !== {2'b00, 32'h0}) begin bad++; $display("FAIL async_clear: got valid=%b fault=%b rdata=%h expected all zero", rsp_valid, rsp_fault, rsp_rdata); end
    @(negedge clock);
    reset_n = 1'b1;
    rsp_ready = 1'b1;
    $display("txn reset-mid scenarios done");
  endtask

  task automatic test_zero_wait();
    @(negedge clock);
    z_req_valid = 1'b1; z_req_addr = 32'h8; z_req_write = 1'b1;
    z_req_width = WORD; z_req_sign_extend = 1'b0; z_req_wdata = 32'h0BADF00D;
    @(posedge clock); #1;
    z_req_valid = 1'b0;
    total++; if ({z_rsp_valid, z_rsp_fault} !== 2'b10) begin bad++; $display("FAIL z_store_lat1: got valid=%b fault=%b expected valid=1 fault=0", z_rsp_valid, z_rsp_fault); end
    @(posedge clock); #1;
    total++; if ({z_rsp_valid, z_req_ready} !== 2'b01) begin bad++; $display("FAIL z_handshake: got valid=%b req_ready=%b expected valid=0 req_ready=1", z_rsp_valid, z_req_ready); end
    @(negedge clock);
    z_req_valid = 1'b1; z_req_write = 1'b0;
    @(posedge clock); #1;
    z_req_valid = 1'b0;
    total++; if ({z_rsp_valid, z_rsp_rdata} !== {1'b1, 32'h0BADF00D}) begin bad++; $display("FAIL z_load_lat1: got valid=%b rdata=%h expected valid=1 rdata=0badf00d", z_rsp_valid, z_rsp_rdata); end
    @(posedge clock); #1;
    @(negedge clock);
    z_req_valid = 1'b1; z_req_addr = 32'h9; z_req_width = HALF;
    @(posedge clock); #1;
    z_req_valid = 1'b0;
    total++; if ({z_rsp_valid, z_rsp_fault, z_rsp_rdata} !== {2'b11, 32'h0}) begin bad++; $display("FAIL z_half_fault: got valid=%b fault=%b rdata=%h expected valid=1 fault=1 rdata=00000000", z_rsp_valid, z_rsp_fault, z_rsp_rdata); end
    @(posedge clock); #1;
    $display("txn zero-wait instance done");
  endtask

  initial begin
    req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_width = 2'b00;
    req_sign_extend = 1'b0; req_wdata = '0; rsp_ready = 1'b1;
    z_req_valid = 1'b0; z_req_addr = '0; z_req_write = 1'b0; z_req_width = 2'b00;
    z_req_sign_extend = 1'b0; z_req_wdata = '0; z_rsp_ready = 1'b1;
    test_reset();
    test_word_rw();
    test_subword();
    test_misalign();
    test_range();
    test_backpressure();
    test_reset_mid();
    test_zero_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
